// File: rtl/oam_dma_engine.sv
// oam_dma_engine
//   Game Boy OAM DMA bus master. A trigger (CPU write to FF46) copies LEN
//   bytes from {eff_page, 8'h00} to DEST_BASE through the MMU request port,
//   one byte at a time (READ then WRITE, one outstanding request).
//   Pages E0..FF are remapped down by 8'h20 (echo RAM) for the source;
//   page_reg keeps the raw value written for FF46 readback.
//
// Parameters: LEN (1..256), DEST_BASE, START_DELAY (0..15 idle cycles
//   between trigger and first read).
//
// Optional feature macro: OAM_DMA_RESTART_EN
//   defined   : a trigger while active restarts the copy from byte 0 with the
//               new page (any outstanding request is completed and discarded).
//   undefined : triggers while active are ignored.
//
// Ports:
//   clk, reset (async, active-low)
//   trig_valid, trig_page           : FF46 write strobe and value
//   req_op, req_size, req_addr,
//   req_wdata                       : MMU request (op 00 NONE/01 READ/10 WRITE)
//   resp_valid, resp_rdata          : MMU completion, read data in [7:0]
//   dma_active                      : transfer in progress (incl. delay)
//   page_reg                        : FF46 readback
//   done_pulse                      : one cycle after the final write completes
module oam_dma_engine #(
  parameter int unsigned LEN         = 160,
  parameter logic [15:0] DEST_BASE   = 16'hFE00,
  parameter int unsigned START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig_valid,
  input  logic [7:0]  trig_page,
  output logic [1:0]  req_op,
  output logic        req_size,
  output logic [15:0] req_addr,
  output logic [15:0] req_wdata,
  input  logic        resp_valid,
  input  logic [15:0] resp_rdata,
  output logic        dma_active,
  output logic [7:0]  page_reg,
  output logic        done_pulse
);

  typedef enum logic [1:0] {IDLE, DELAY, READ, WRITE} state_t;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  localparam logic [8:0] LAST_CNT = 9'(LEN - 1);
  // Only meaningful when START_DELAY > 0; DELAY is unreachable otherwise.
  localparam logic [3:0] DLY_LAST = 4'(START_DELAY - 1);
  localparam state_t     FIRST_ST = (START_DELAY == 0) ? READ : DELAY;

  function automatic logic [7:0] eff_page(input logic [7:0] p);
    return (p >= 8'hE0) ? (p - 8'h20) : p;
  endfunction

  state_t      state, state_nx;
  logic [8:0]  cnt;
  logic [7:0]  src_page;
  logic [7:0]  data_lat;
  logic [7:0]  page_q;
  logic [7:0]  pend_page;
  logic [3:0]  dly;
  logic        done_q;
  logic        pend_valid;

  logic        busy;
  logic        last_done;
  logic        start_acc;
  logic [7:0]  start_page;
  logic        reload;
  logic [7:0]  reload_page;

  logic        unused_rdata_hi;
  assign unused_rdata_hi = ^resp_rdata[15:8];

`ifdef OAM_DMA_RESTART_EN
  logic restart_q;
  logic trig_active;
`endif

  // Event decode shared by next-state and datapath logic.
  always_comb begin
    busy        = (state == READ) || (state == WRITE);
    last_done   = (state == WRITE) && resp_valid && (cnt == LAST_CNT);
    start_acc   = (state == IDLE) && (trig_valid || pend_valid);
    start_page  = trig_valid ? trig_page : pend_page;
    reload      = 1'b0;
    reload_page = page_q;
`ifdef OAM_DMA_RESTART_EN
    // A trigger landing exactly on the final write's completion is not a
    // restart: it is queued and started from IDLE like any other trigger.
    trig_active = trig_valid && (state != IDLE) && !(last_done && !restart_q);
    reload      = ((state == DELAY) && trig_valid) ||
                  (busy && resp_valid && (restart_q || trig_active));
    reload_page = trig_valid ? trig_page : page_q;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_acc) state_nx = FIRST_ST;
      DELAY: begin
        if (reload)               state_nx = FIRST_ST;
        else if (dly == DLY_LAST) state_nx = READ;
      end
      READ: begin
        if (resp_valid) state_nx = reload ? FIRST_ST : WRITE;
      end
      WRITE: begin
        if (resp_valid) begin
          if (reload)                 state_nx = FIRST_ST;
          else if (cnt == LAST_CNT)   state_nx = IDLE;
          else                        state_nx = READ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: counter, page, data latch, done and queued-trigger registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      src_page   <= '0;
      data_lat   <= '0;
      page_q     <= '1;
      pend_page  <= '0;
      pend_valid <= 1'b0;
      dly        <= '0;
      done_q     <= 1'b0;
`ifdef OAM_DMA_RESTART_EN
      restart_q  <= 1'b0;
`endif
    end else begin
      done_q <= last_done && !reload;

      if (start_acc) begin
        page_q     <= start_page;
        src_page   <= eff_page(start_page);
        cnt        <= '0;
        dly        <= '0;
        pend_valid <= 1'b0;
      end else if (reload) begin
        src_page <= eff_page(reload_page);
        cnt      <= '0;
        dly      <= '0;
      end else begin
        unique case (state)
          DELAY: dly <= dly + 4'd1;
          READ:  if (resp_valid) data_lat <= resp_rdata[7:0];
          WRITE: if (resp_valid && (cnt != LAST_CNT)) cnt <= cnt + 9'd1;
          default: ;
        endcase
      end

      if (last_done && trig_valid && !reload) begin
        pend_valid <= 1'b1;
        pend_page  <= trig_page;
      end

`ifdef OAM_DMA_RESTART_EN
      // page_reg follows FF46 at once; the source page used for addressing
      // only changes when the in-flight request has completed.
      if (trig_active) page_q <= trig_page;
      if (busy && resp_valid)        restart_q <= 1'b0;
      else if (trig_active && busy)  restart_q <= 1'b1;
`endif
    end
  end

  // Output logic.
  always_comb begin
    req_op     = OP_NONE;
    req_size   = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    dma_active = (state != IDLE);
    page_reg   = page_q;
    done_pulse = done_q;
    unique case (state)
      READ: begin
        req_op   = OP_READ;
        req_addr = {src_page, cnt[7:0]};
      end
      WRITE: begin
        req_op    = OP_WRITE;
        req_addr  = DEST_BASE + {7'd0, cnt};
        req_wdata = {8'h00, data_lat};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_engine.sv
module tb_oam_dma_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        trig_valid;
  logic [7:0]  trig_page;
  logic [1:0]  req_op;
  logic        req_size;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        dma_active;
  logic [7:0]  page_reg;
  logic        done_pulse;

  always #5 clk = ~clk;

  oam_dma_engine #(.LEN(160), .DEST_BASE(16'hFE00), .START_DELAY(1)) dut (
    .clk(clk), .reset(reset), .trig_valid(trig_valid), .trig_page(trig_page),
    .req_op(req_op), .req_size(req_size), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .dma_active(dma_active), .page_reg(page_reg), .done_pulse(done_pulse)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- memory / MMU model ----------------
  logic [7:0]  mem [0:65535];
  int          lat_max = 0;
  logic        mem_resp;
  logic        stray = 1'b0;
  logic        m_busy;
  int          m_wait;
  int          m_w;
  logic [1:0]  c_op;
  logic [15:0] c_addr, c_wdata;
  int          stab_bad = 0;

  assign resp_valid = mem_resp | stray;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_resp   <= 1'b0;
      m_busy     <= 1'b0;
      m_wait     <= 0;
      resp_rdata <= '0;
    end else begin
      mem_resp <= 1'b0;
      if (!mem_resp && req_op != 2'b00) begin
        if (m_busy && (req_op !== c_op || req_addr !== c_addr || req_wdata !== c_wdata))
          stab_bad <= stab_bad + 1;
        if (!m_busy) begin
          c_op <= req_op; c_addr <= req_addr; c_wdata <= req_wdata;
          m_w = $urandom_range(lat_max, 0);
        end else begin
          m_w = m_wait;
        end
        if (m_w == 0) begin
          mem_resp <= 1'b1;
          m_busy   <= 1'b0;
          if (req_op == 2'b01) resp_rdata <= {8'($urandom), mem[req_addr]};
          else                 mem[req_addr] <= req_wdata[7:0];
        end else begin
          m_busy <= 1'b1;
          m_wait <= m_w - 1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;
  ev_t evq[$];
  int  act_cycles = 0;
  int  done_cnt   = 0;
  int  req_seen   = 0;

  always @(negedge clk) begin
    ev_t e;
    if (dma_active) act_cycles++;
    if (done_pulse) done_cnt++;
    if (req_op != 2'b00) req_seen++;
    if (mem_resp && req_op != 2'b00) begin
      e.op   = req_op;
      e.addr = req_addr;
      e.data = (req_op == 2'b01) ? resp_rdata[7:0] : req_wdata[7:0];
      evq.push_back(e);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] src_addr(input logic [7:0] p, input int i);
    int pg;
    pg = (p >= 224) ? int'(p) - 32 : int'(p);
    return 16'(pg * 256 + (i % 256));
  endfunction

  logic [7:0] ref_a [0:159];
  logic [7:0] ref_b [0:159];

  task automatic snap(input logic [7:0] p, input bit to_b);
    for (int i = 0; i < 160; i++) begin
      if (to_b) ref_b[i] = mem[src_addr(p, i)];
      else      ref_a[i] = mem[src_addr(p, i)];
    end
  endtask

  task automatic clear_dest();
    for (int i = 0; i < 160; i++) mem[16'hFE00 + 16'(i)] = 8'hEE;
  endtask

  task automatic pulse_trig(input logic [7:0] p);
    trig_valid = 1'b1;
    trig_page  = p;
    @(negedge clk);
    trig_valid = 1'b0;
  endtask

  task automatic wait_done(input int n_done, input int budget);
    for (int n = 0; n < budget && done_cnt < n_done; n++) @(negedge clk);
    repeat (5) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; trig_valid = 1'b0; trig_page = 8'h00;
    repeat (3) @(negedge clk);
    total++; if (req_op !== 2'b00)     begin bad++; $display("FAIL reset_req_op got=%h exp=0", req_op); end
    total++; if (req_addr !== 16'h0)   begin bad++; $display("FAIL reset_req_addr got=%h exp=0", req_addr); end
    total++; if (req_wdata !== 16'h0)  begin bad++; $display("FAIL reset_req_wdata got=%h exp=0", req_wdata); end
    total++; if (req_size !== 1'b0)    begin bad++; $display("FAIL reset_req_size got=%h exp=0", req_size); end
    total++; if (dma_active !== 1'b0)  begin bad++; $display("FAIL reset_active got=%h exp=0", dma_active); end
    total++; if (page_reg !== 8'hFF)   begin bad++; $display("FAIL reset_page_reg got=%h exp=ff", page_reg); end
    total++; if (done_pulse !== 1'b0)  begin bad++; $display("FAIL reset_done got=%h exp=0", done_pulse); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int errs, first;
    int seen0, done0;
    for (int i = 0; i < 160; i++) mem[16'hC100 + 16'(i)] = 8'(i);
    clear_dest();
    lat_max = 0; evq.delete(); act_cycles = 0; done_cnt = 0; stab_bad = 0;
    pulse_trig(8'hC1);
    total++; if (dma_active !== 1'b1) begin bad++; $display("FAIL basic_active_rise got=%h exp=1", dma_active); end
    stray = 1'b1;                     // response pulse during DELAY must be ignored
    @(negedge clk);
    stray = 1'b0;
    wait_done(1, 2000);
    total++; if (act_cycles != 641) begin bad++; $display("FAIL basic_active_cycles got=%0d exp=641", act_cycles); end
    total++; if (done_cnt != 1)     begin bad++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    total++; if (evq.size() != 320) begin bad++; $display("FAIL basic_event_count got=%0d exp=320", evq.size()); end
    errs = 0; first = -1;
    for (int i = 0; i < 160 && 2 * i + 1 < evq.size(); i++) begin
      if (evq[2*i].op !== 2'b01 || evq[2*i].addr !== 16'hC100 + 16'(i) ||
          evq[2*i+1].op !== 2'b10 || evq[2*i+1].addr !== 16'hFE00 + 16'(i) ||
          evq[2*i+1].data !== 8'(i)) begin
        errs++; if (first < 0) first = i;
      end
    end
    total++; if (errs != 0) begin bad++; $display("FAIL basic_sequence got=%0d bad bytes (first %0d) exp=0", errs, first); end
    errs = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== 8'(i)) errs++;
    total++; if (errs != 0)        begin bad++; $display("FAIL basic_dest got=%0d wrong exp=0", errs); end
    total++; if (page_reg !== 8'hC1) begin bad++; $display("FAIL basic_page_reg got=%h exp=c1", page_reg); end
    // Stray response while idle: nothing may start.
    seen0 = req_seen; done0 = done_cnt;
    stray = 1'b1; @(negedge clk); stray = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (req_seen != seen0 || dma_active !== 1'b0 || done_cnt != done0)
      begin bad++; $display("FAIL idle_stray got=%0d reqs exp=0", req_seen - seen0); end
  endtask

  task automatic test_remap_latency();
    int errs;
    snap(8'hE3, 1'b0);
    clear_dest();
    lat_max = 5; evq.delete(); done_cnt = 0; stab_bad = 0;
    pulse_trig(8'hE3);
    wait_done(1, 8000);
    total++; if (done_cnt != 1)      begin bad++; $display("FAIL remap_done got=%0d exp=1", done_cnt); end
    total++; if (page_reg !== 8'hE3) begin bad++; $display("FAIL remap_page_reg got=%h exp=e3", page_reg); end
    total++; if (stab_bad != 0)      begin bad++; $display("FAIL remap_stability got=%0d exp=0", stab_bad); end
    total++; if (evq.size() != 320)  begin bad++; $display("FAIL remap_event_count got=%0d exp=320", evq.size()); end
    errs = 0;
    for (int i = 0; i < 160 && 2 * i + 1 < evq.size(); i++) begin
      if (evq[2*i].op !== 2'b01 || evq[2*i].addr !== 16'hC300 + 16'(i) ||
          evq[2*i+1].op !== 2'b10 || evq[2*i+1].addr !== 16'hFE00 + 16'(i) ||
          evq[2*i+1].data !== ref_a[i]) errs++;
    end
    total++; if (errs != 0) begin bad++; $display("FAIL remap_sequence got=%0d wrong exp=0", errs); end
  endtask

  task automatic test_reset_mid();
    lat_max = 2; evq.delete();
    pulse_trig(8'h40);
    for (int n = 0; n < 4000 && evq.size() < 100; n++) @(negedge clk);
    total++; if (evq.size() < 100) begin bad++; $display("FAIL mid_reach_byte50 got=%0d exp=100", evq.size()); end
    #2 reset = 1'b0;
    #1;
    total++; if (req_op !== 2'b00 || req_addr !== 16'h0 || req_wdata !== 16'h0)
      begin bad++; $display("FAIL mid_reset_req got=%h/%h/%h exp=0/0/0", req_op, req_addr, req_wdata); end
    total++; if (dma_active !== 1'b0 || page_reg !== 8'hFF || done_pulse !== 1'b0)
      begin bad++; $display("FAIL mid_reset_status got=%h/%h/%h exp=0/ff/0", dma_active, page_reg, done_pulse); end
    @(negedge clk);
    reset = 1'b1;
    req_seen = 0;
    repeat (20) @(negedge clk);
    total++; if (req_seen != 0 || dma_active !== 1'b0)
      begin bad++; $display("FAIL mid_after_reset got=%0d reqs exp=0", req_seen); end
  endtask

  task automatic test_second_trigger();
    int errs;
    logic [7:0] exp_page;
    snap(8'h80, 1'b0);
    snap(8'hD0, 1'b1);
    clear_dest();
    lat_max = 3; evq.delete(); done_cnt = 0; stab_bad = 0;
    pulse_trig(8'h80);
    for (int n = 0; n < 4000 && evq.size() < 40; n++) @(negedge clk);
    total++; if (evq.size() < 40) begin bad++; $display("FAIL second_reach_byte20 got=%0d exp=40", evq.size()); end
    pulse_trig(8'hD0);
    wait_done(1, 8000);
    repeat (20) @(negedge clk);
    errs = 0;
`ifdef OAM_DMA_RESTART_EN
    exp_page = 8'hD0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== ref_b[i]) errs++;
`else
    exp_page = 8'h80;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== ref_a[i]) errs++;
`endif
    total++; if (done_cnt != 1)         begin bad++; $display("FAIL second_done got=%0d exp=1", done_cnt); end
    total++; if (page_reg !== exp_page) begin bad++; $display("FAIL second_page_reg got=%h exp=%h", page_reg, exp_page); end
    total++; if (errs != 0)             begin bad++; $display("FAIL second_dest got=%0d wrong exp=0", errs); end
    total++; if (stab_bad != 0)         begin bad++; $display("FAIL second_stability got=%0d exp=0", stab_bad); end
  endtask

  task automatic test_back_to_back();
    int errs;
    bit hit;
    snap(8'h12, 1'b0);
    snap(8'h34, 1'b1);
    clear_dest();
    lat_max = 2; evq.delete(); done_cnt = 0;
    pulse_trig(8'h12);
    hit = 1'b0;
    for (int n = 0; n < 4000 && !hit; n++) begin
      @(negedge clk);
      hit = mem_resp && req_op == 2'b10 && req_addr == 16'hFE9F;
    end
    total++; if (!hit) begin bad++; $display("FAIL b2b_final_write got=0 exp=1"); end
    pulse_trig(8'h34);
    wait_done(2, 8000);
    errs = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + 16'(i)] !== ref_b[i]) errs++;
    total++; if (done_cnt != 2)       begin bad++; $display("FAIL b2b_done got=%0d exp=2", done_cnt); end
    total++; if (page_reg !== 8'h34)  begin bad++; $display("FAIL b2b_page_reg got=%h exp=34", page_reg); end
    total++; if (evq.size() != 640)   begin bad++; $display("FAIL b2b_event_count got=%0d exp=640", evq.size()); end
    total++; if (errs != 0)           begin bad++; $display("FAIL b2b_dest got=%0d wrong exp=0", errs); end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    test_reset();
    test_basic();
    test_remap_latency();
    test_reset_mid();
    test_second_trigger();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
